// File: rtl/add_sub_seq_pkg.sv
// Shared definitions for the sliced adder/subtractor: op encodings, default sizes, FSM states.
package add_sub_seq_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/add_sub_seq_if.sv
// Start/done handshake and operand/result bus between the execute stage and add_sub_seq.
interface add_sub_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, overflow
  );
endinterface

// File: rtl/add_sub_seq_chunk.sv
// CHUNK-bit ripple adder built from full_adder cells; reused for every slice of an operation.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] c;

  assign c[0] = cin;
  assign cout = c[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end
endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per cycle, LSB slice first.
//
//   state  | meaning
//   S_IDLE | waiting for start; done pulses in the first idle cycle after an operation
//   S_RUN  | one slice per cycle, carry registered between slices
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  add_sub_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, cout_q, ovf_q, done_q;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_cout;
  logic             accept, last;

  assign accept  = (state == S_IDLE) && bus.start;
  assign last    = (state == S_RUN) && (cnt == LAST);
  assign slice_a = a_q[int'(cnt)*CHUNK +: CHUNK];
  assign slice_b = b_q[int'(cnt)*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave IDLE on accepted start, return after the final slice
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b ^ {WIDTH{bus.sub == ALU_OP_SUB}};
        carry_q <= (bus.sub == ALU_OP_SUB) ? 1'b1 : bus.cin;
        cnt     <= '0;
      end else if (state == S_RUN) begin
        s_q[int'(cnt)*CHUNK +: CHUNK] <= slice_s;
        carry_q <= slice_cout;
        if (last) begin
          // Counter parks at 0 so the slice select never leaves the operand range.
          cnt    <= '0;
          done_q <= 1'b1;
          cout_q <= slice_cout;
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[CHUNK-1] != a_q[WIDTH-1]);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.busy     = (state == S_RUN);
  assign bus.done     = done_q;
  assign bus.s        = s_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed and randomised checks of add_sub_seq at several WIDTH/CHUNK combinations.
module tb_add_sub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_sub_seq_if #(.WIDTH(64)) bus   ();
  add_sub_seq_if #(.WIDTH(64)) bus8  ();
  add_sub_seq_if #(.WIDTH(64)) bus64 ();
  add_sub_seq_if #(.WIDTH(32)) bus1  ();

  add_sub_seq #(.WIDTH(64), .CHUNK(16)) dut    (.clk(clk), .rst(rst), .bus(bus));
  add_sub_seq #(.WIDTH(64), .CHUNK(8))  dut_c8 (.clk(clk), .rst(rst), .bus(bus8));
  add_sub_seq #(.WIDTH(64), .CHUNK(64)) dut_c64(.clk(clk), .rst(rst), .bus(bus64));
  add_sub_seq #(.WIDTH(32), .CHUNK(1))  dut_c1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns {ovf, cout, s}
  function automatic logic [65:0] ref64(input logic [63:0] av, bv, input logic sv, cv);
    logic [63:0] bb;
    logic [64:0] sum;
    bb  = sv ? ~bv : bv;
    sum = {1'b0, av} + {1'b0, bb} + {64'd0, (sv ? 1'b1 : cv)};
    return {((av[63] == bb[63]) && (sum[63] != av[63])), sum};
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] av, bv, input logic sv, cv);
    logic [31:0] bb;
    logic [32:0] sum;
    bb  = sv ? ~bv : bv;
    sum = {1'b0, av} + {1'b0, bb} + {32'd0, (sv ? 1'b1 : cv)};
    return {((av[31] == bb[31]) && (sum[31] != av[31])), sum};
  endfunction

  task automatic run_main(input logic [63:0] av, bv, input logic sv, cv,
                          output int lat, output int bcnt);
    @(posedge clk); #1;
    bus.a = av; bus.b = bv; bus.sub = sv; bus.cin = cv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [63:0] av, bv, input logic sv, cv,
                          input logic [63:0] es, input logic ec, eo);
    int lat, bcnt;
    run_main(av, bv, sv, cv, lat, bcnt);
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
    chk({tag, "_s"}, bus.s, es);
    chk({tag, "_cout"}, {63'd0, bus.cout}, {63'd0, ec});
    chk({tag, "_ovf"}, {63'd0, bus.overflow}, {63'd0, eo});
    chk({tag, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_s_held"}, bus.s, es);
  endtask

  task automatic sweep_op(input logic [63:0] av, bv, input logic sv, cv);
    int l8, l64, l1;
    logic [65:0] r8, r64, e64;
    logic [33:0] r1, e32;
    l8 = 0; l64 = 0; l1 = 0; r8 = '0; r64 = '0; r1 = '0;
    e64 = ref64(av, bv, sv, cv);
    e32 = ref32(av[31:0], bv[31:0], sv, cv);
    @(posedge clk); #1;
    bus8.a = av;  bus8.b = bv;  bus8.sub = sv;  bus8.cin = cv;  bus8.start = 1'b1;
    bus64.a = av; bus64.b = bv; bus64.sub = sv; bus64.cin = cv; bus64.start = 1'b1;
    bus1.a = av[31:0]; bus1.b = bv[31:0]; bus1.sub = sv; bus1.cin = cv; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus64.start = 1'b0; bus1.start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (bus8.done && l8 == 0)   begin l8 = cyc;  r8 = {bus8.overflow, bus8.cout, bus8.s}; end
      if (bus64.done && l64 == 0) begin l64 = cyc; r64 = {bus64.overflow, bus64.cout, bus64.s}; end
      if (bus1.done && l1 == 0)   begin l1 = cyc;  r1 = {bus1.overflow, bus1.cout, bus1.s}; end
      if (l8 != 0 && l64 != 0 && l1 != 0) break;
    end
    chk("c8_latency", 64'(l8), 64'd8);
    chk("c8_s", r8[63:0], e64[63:0]);
    chk("c8_cout_ovf", {62'd0, r8[65:64]}, {62'd0, e64[65:64]});
    chk("c64_latency", 64'(l64), 64'd1);
    chk("c64_s", r64[63:0], e64[63:0]);
    chk("c64_cout_ovf", {62'd0, r64[65:64]}, {62'd0, e64[65:64]});
    chk("c1_latency", 64'(l1), 64'd32);
    chk("c1_s", {32'd0, r1[31:0]}, {32'd0, e32[31:0]});
    chk("c1_cout_ovf", {62'd0, r1[33:32]}, {62'd0, e32[33:32]});
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [63:0] ra, rb;
    bus.start = 0;   bus.sub = 0;   bus.a = '0;   bus.b = '0;   bus.cin = 0;
    bus8.start = 0;  bus8.sub = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;
    bus64.start = 0; bus64.sub = 0; bus64.a = '0; bus64.b = '0; bus64.cin = 0;
    bus1.start = 0;  bus1.sub = 0;  bus1.a = '0;  bus1.b = '0;  bus1.cin = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_s", bus.s, 64'd0);
    chk("reset_flags", {62'd0, bus.cout, bus.overflow}, 64'd0);
    rst = 1'b0;

    directed("add_small", 64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0);
    directed("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    directed("sub_borrow", 64'h3, 64'h5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("sub_cin_ign", 64'h3, 64'h5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("add_cin", 64'h0000_FFFF_0000_FFFF, 64'h0, 1'b0, 1'b1,
             64'h0000_FFFF_0001_0000, 1'b0, 1'b0);

    // start held high: new operands while busy are ignored, done-cycle start is accepted
    @(posedge clk); #1;
    bus.a = 64'd10; bus.b = 64'd20; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 64'hDEAD_BEEF_0000_0999; bus.b = 64'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.a = 64'h100; bus.b = 64'h23;
    @(posedge clk); #1;
    chk("hs_first_done", {63'd0, bus.done}, 64'd1);
    chk("hs_first_s", bus.s, 64'd30);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("hs_second_busy", {63'd0, bus.busy}, 64'd1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_second_latency", 64'(lat), 64'd4);
    chk("hs_second_s", bus.s, 64'h123);

    // reset during the second RUN cycle
    @(posedge clk); #1;
    bus.a = 64'h1111_1111_1111_1111; bus.b = 64'h1111_1111_1111_1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_run_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    chk("rst_partial_s", bus.s, 64'h0000_0000_0000_2222);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
    chk("rst_mid_s", bus.s, 64'd0);
    chk("rst_mid_flags", {62'd0, bus.cout, bus.overflow}, 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'd0);

    // parameter sweep against the reference model
    sweep_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    sweep_op(64'h8000_0000_8000_0000, 64'h1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      sweep_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
